add_32bit_serial: RTL and testbench
===================================

ADD_32BIT_SERIAL -- requirements
Module: add_32bit_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands a, b, c_i valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  addend (e.g. difference d from sub_32bit).
REQ-007 SHALL have port b  input  WIDTH  addend (e.g. subtrahend).
REQ-008 SHALL have port c_i  input  1  carry into bit 0.
REQ-009 SHALL have port s  output  WIDTH  sum a+b+c_i mod 2^WIDTH.
REQ-010 SHALL have port c_o  output  1  carry out of bit WIDTH-1.
REQ-011 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR c_o).
REQ-012 SHALL have port out_valid  output  1  s, c_o, ovf valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready at edge, register a, b into shift registers, c_i into carry flop, bit counter=0, go RUN.
REQ-016 SHALL, in RUN, compute one bit per cycle, LSB first: sum bit = a[i]^b[i]^carry, carry updated via majority, sum shifted in MSB-first into result register.
REQ-017 SHALL, in RUN with counter==WIDTH-1, latch c_o and ovf (carry into bit WIDTH-1 XOR final carry) and go DONE; otherwise increment counter.
REQ-018 SHALL assert out_valid exactly WIDTH cycles after acceptance edge (WIDTH+1 edges from in_valid sample to first out_valid-high cycle for WIDTH=32: accept edge k, out_valid high after edge k+32).
REQ-019 SHALL hold s, c_o, ovf stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
REQ-020 SHALL, in DONE on out_ready=1, go IDLE; no new operand accepted in that same cycle (in_ready stays 0 until IDLE).
REQ-021 SHALL ignore in_valid and operand changes while in RUN or DONE.
REQ-022 SHALL keep s, c_o, ovf holding last result in IDLE; only out_valid qualifies them.
REQ-023 SHALL wrap sum modulo 2^WIDTH; no saturation.

Reset
REQ-024 SHALL, when rst=1 at an edge, force state IDLE, counter 0, carry 0, s=0, c_o=0, ovf=0, out_valid=0, in_ready=1 after that edge.
REQ-025 SHALL let reset override any state including mid-RUN and DONE; in-flight operation discarded, no out_valid produced.

Structure
REQ-026 SHALL place state encoding typedef (IDLE/RUN/DONE) and default WIDTH constant in shared package alu_pkg.
REQ-027 SHALL instantiate one sub-module full_add (ports a, b, c_i, s_o, c_o), counterpart of full_sub, for the per-bit cell.
REQ-028 SHALL size counter as clog2(WIDTH) bits; no other arithmetic operators on the datapath.

Verification
REQ-029 SHALL test a=0xFFFFFFFF, b=0x00000000, c_i=1 -> s=0x00000000, c_o=1, ovf=0, out_valid 32 cycles after accept.
REQ-030 SHALL test a=0x7FFFFFFF, b=0x00000001, c_i=0 -> s=0x80000000, c_o=0, ovf=1.
REQ-031 SHALL test round trip: sub_32bit(5,7) gives d=0xFFFFFFFE, b_o=1; add(a=0xFFFFFFFE, b=7, c_i=0) -> s=0x00000005, c_o=1.
REQ-032 SHALL test backpressure: out_ready=0 for 5 cycles after out_valid -> s, c_o, ovf, out_valid constant, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 SHALL test rst=1 at counter==10 in RUN -> next cycle IDLE, out_valid=0, in_ready=1, s=0; new operation then completes correctly.
REQ-034 SHALL test in_valid toggling with changing operands during RUN -> result equals sum of originally accepted operands only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/sub family: FSM state encoding and
// the default operand width.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell used by the serial adder for each bit position.
module full_add (
  input  logic a,
  input  logic b,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a ^ b ^ c_i;
  assign c_o = (a & b) | (a & c_i) | (b & c_i);

endmodule

// File: rtl/add_32bit_serial.sv
// Bit-serial adder: accepts a, b, c_i, adds one bit per cycle LSB first and
// presents s/c_o/ovf after WIDTH cycles.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and the producer holds data until then.
module add_32bit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  output logic [WIDTH-1:0] s,
  output logic             c_o,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output state_e           dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_o_q, c_o_d;
  logic             ovf_q, ovf_d;
  logic             bit_s, bit_c;

  full_add u_full_add (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .c_i (carry_q),
    .s_o (bit_s),
    .c_o (bit_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    c_o_d   = c_o_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = bit_c;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB, bit_c the carry out of it
          s_d     = res_d;
          c_o_d   = bit_c;
          ovf_d   = carry_q ^ bit_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_o_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      c_o_q   <= c_o_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_o       = c_o_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add_32bit_serial.sv
// Bench for the bit-serial adder: directed and random vectors, backpressure,
// mid-run reset and operand churn while busy.
module tb_add_32bit_serial;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int LAT = 32;
  localparam int BUDGET = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_i = 1'b0;
  logic [W-1:0] s;
  logic         c_o;
  logic         ovf;
  logic         out_valid;
  logic         out_ready = 1'b0;
  state_e       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // {c_o, ovf, s}
  logic [W+1:0] exp_q[$];

  add_32bit_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_i       (c_i),
    .s         (s),
    .c_o       (c_o),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
    logic [W:0]   full;
    logic         c_msb;
    full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    c_msb = x[W-1] ^ y[W-1] ^ full[W-1];
    return {full[W], c_msb ^ full[W], full[W-1:0]};
  endfunction

  // Driver: wait for in_ready, present one operand set for one edge.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input bit push, output bit timeout);
    int n;
    n = 0;
    timeout = 0;
    while (!in_ready && n < BUDGET) begin
      step();
      n++;
    end
    if (!in_ready) begin
      timeout = 1;
      return;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    c_i = ci;
    if (push) exp_q.push_back(model(x, y, ci));
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_out(output int lat, output bit timeout);
    lat = 0;
    timeout = 0;
    while (!out_valid) begin
      if (lat >= BUDGET) begin
        timeout = 1;
        return;
      end
      step();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b state=%0d, want 1 0 0",
               in_ready, out_valid, dbg_state);
    end
    n_tests++;
    if (s !== '0 || c_o !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: s=%h c_o=%b ovf=%b, want 0 0 0", s, c_o, ovf);
    end
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci);
    bit to;
    int lat;
    logic [W+1:0] exp;
    drive_op(x, y, ci, 1'b1, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready never rose within %0d cycles", name, BUDGET);
      return;
    end
    wait_out(lat, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || lat !== LAT) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles (timeout=%0d), want %0d", name, lat, to, LAT);
      if (to) return;
    end
    n_tests++;
    if ({c_o, ovf, s} !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got c_o=%b ovf=%b s=%h, want c_o=%b ovf=%b s=%h",
               name, c_o, ovf, s, exp[W+1], exp[W], exp[W-1:0]);
    end
    release_out();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b, want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int lat;
    logic [W+1:0] exp;
    drive_op(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1, to);
    wait_out(lat, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL bp_wait: out_valid not seen within %0d cycles", BUDGET);
      return;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      step();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {c_o, ovf, s} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b c_o=%b ovf=%b s=%h, want 1 0 %b %b %h",
                 i, out_valid, in_ready, c_o, ovf, s, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE || s !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b state=%0d s=%h, want 0 1 0 %h",
               out_valid, in_ready, dbg_state, s, exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int seen;
    drive_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, to);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (dbg_state !== IDLE || out_valid !== 1'b0 || in_ready !== 1'b1 || s !== '0 ||
        c_o !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_run: state=%0d out_valid=%b in_ready=%b s=%h c_o=%b ovf=%b, want 0 0 1 0 0 0",
               dbg_state, out_valid, in_ready, s, c_o, ovf);
    end
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_output: out_valid high %0d cycles, want 0", seen);
    end
    test_vector("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_ignore_inputs();
    bit to;
    int n;
    logic [W+1:0] exp;
    drive_op(32'hCAFE_0001, 32'h1357_9BDF, 1'b1, 1'b1, to);
    n = 0;
    while (!out_valid && n < BUDGET) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      c_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_tests++;
    if (!out_valid || {c_o, ovf, s} !== exp) begin
      n_fail++;
      $display("FAIL ignore_inputs: out_valid=%b c_o=%b ovf=%b s=%h, want 1 %b %b %h",
               out_valid, c_o, ovf, s, exp[W+1], exp[W], exp[W-1:0]);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      test_vector("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_vector("all_ones_plus_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    test_vector("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    test_vector("round_trip", 32'hFFFF_FFFE, 32'h0000_0007, 1'b0);
    test_vector("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0);
    test_reset_mid_run();
    test_backpressure();
    test_ignore_inputs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
